// File: rtl/axi_wr_queue_if.sv
// axi_wr_queue_if: AXI write channels (AW, W, B) between the write queue and the bus
interface axi_wr_queue_if;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output wid, wdata, wstrb, wlast, wvalid, bready,
      input  awready, wready, bid, bresp, bvalid
   );
   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  wid, wdata, wstrb, wlast, wvalid, bready,
      output awready, wready, bid, bresp, bvalid
   );
endinterface

// File: rtl/axi_wr_queue.sv
// axi_wr_queue: posted line/word write queue draining one AXI write transaction at a time
module axi_wr_queue #(
   parameter int          BYTES_PER_LINE = 16,
   parameter int          DEPTH          = 4,
   parameter logic [3:0]  AXI_ID         = 4'd1,
   localparam int         LINE_WIDTH     = BYTES_PER_LINE * 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  wr_req,
   output logic                  wr_rdy,
   input  logic                  burst,
   input  logic [LINE_WIDTH-1:0] data,
   input  logic [31:0]           addr,
   input  logic [1:0]            size,
   input  logic [3:0]            strb,
   input  logic [31:0]           rd_addr,
   output logic                  rd_hit,
   input  logic                  read_unfinish,
   output logic                  wr_idle,
   output logic                  err,
   output logic [31:0]           err_addr,
   input  logic                  err_clr,
   axi_wr_queue_if.master        axi
);
   localparam int WORDS = BYTES_PER_LINE / 4;
   localparam int OB    = $clog2(BYTES_PER_LINE);
   localparam int BW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int QA    = $clog2(DEPTH);
   localparam int PW    = QA + 1;

   typedef enum logic [2:0] {IDLE, AW_W, AW, W, WAIT} state_t;

   logic [LINE_WIDTH-1:0] data_m  [DEPTH];
   logic [31:0]           addr_m  [DEPTH];
   logic                  burst_m [DEPTH];
   logic [1:0]            size_m  [DEPTH];
   logic [3:0]            strb_m  [DEPTH];

   logic [PW-1:0]         head_q, head_d, tail_q, tail_d, count;
   state_t                state_q, state_d;
   logic [BW-1:0]         beat_q, beat_d;
   logic                  err_q, err_d;
   logic [31:0]           err_addr_q, err_addr_d;
   logic                  full, empty, push, pop, new_err, aw_hs, w_hs, w_last_hs;
   logic [QA-1:0]         hi;
   logic [LINE_WIDTH-1:0] h_data;
   logic [31:0]           h_addr;
   logic                  h_burst;
   logic [1:0]            h_size;
   logic [3:0]            h_strb;
   logic                  unused_bits;

   assign hi      = head_q[QA-1:0];
   assign h_data  = data_m[hi];
   assign h_addr  = addr_m[hi];
   assign h_burst = burst_m[hi];
   assign h_size  = size_m[hi];
   assign h_strb  = strb_m[hi];

   // Extra pointer MSB distinguishes full from empty when the indices match
   assign count = tail_q - head_q;
   assign empty = tail_q == head_q;
   assign full  = (tail_q[QA] != head_q[QA]) && (tail_q[QA-1:0] == hi);

   assign wr_rdy   = ~full;
   assign push     = wr_req & ~full;
   assign pop      = (state_q == WAIT) & axi.bvalid;
   assign new_err  = pop & axi.bresp[1];
   assign wr_idle  = empty & (state_q == IDLE);
   assign err      = err_q;
   assign err_addr = err_addr_q;

   assign axi.awid    = AXI_ID;
   assign axi.awaddr  = h_burst ? {h_addr[31:OB], {OB{1'b0}}} : h_addr;
   assign axi.awlen   = h_burst ? 8'(WORDS - 1) : 8'd0;
   assign axi.awsize  = h_burst ? 3'd2 : {1'b0, h_size};
   assign axi.awburst = h_burst ? 2'b01 : 2'b00;
   assign axi.awlock  = 2'b00;
   assign axi.awcache = 4'b0000;
   assign axi.awprot  = 3'b000;
   assign axi.awvalid = (state_q == AW_W) | (state_q == AW);
   assign axi.wid     = AXI_ID;
   assign axi.wdata   = 32'(h_data >> {beat_q, 5'd0});
   assign axi.wstrb   = h_burst ? 4'hF : h_strb;
   assign axi.wlast   = ~h_burst | (beat_q == BW'(WORDS - 1));
   assign axi.wvalid  = (state_q == AW_W) | (state_q == W);
   assign axi.bready  = 1'b1;

   assign aw_hs     = axi.awvalid & axi.awready;
   assign w_hs      = axi.wvalid & axi.wready;
   assign w_last_hs = w_hs & axi.wlast;
   assign unused_bits = ^{axi.bid, axi.bresp[0], rd_addr[OB-1:0]};

   always_comb begin
      state_d    = state_q;
      beat_d     = w_hs ? beat_q + BW'(1) : beat_q;
      head_d     = head_q + PW'(pop);
      tail_d     = tail_q + PW'(push);
      err_d      = new_err | (err_q & ~err_clr);
      err_addr_d = (new_err & ~err_q) ? axi.awaddr : err_addr_q;
      case (state_q)
         IDLE: if (!empty && !read_unfinish) begin
            state_d = AW_W;
            beat_d  = '0;
         end
         AW_W:    state_d = (aw_hs & w_last_hs) ? WAIT : w_last_hs ? AW : aw_hs ? W : AW_W;
         AW:      state_d = aw_hs ? WAIT : AW;
         W:       state_d = w_last_hs ? WAIT : W;
         WAIT:    state_d = axi.bvalid ? IDLE : WAIT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         head_q     <= '0;
         tail_q     <= '0;
         beat_q     <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         beat_q     <= beat_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_m[tail_q[QA-1:0]]  <= data;
         addr_m[tail_q[QA-1:0]]  <= addr;
         burst_m[tail_q[QA-1:0]] <= burst;
         size_m[tail_q[QA-1:0]]  <= size;
         strb_m[tail_q[QA-1:0]]  <= strb;
      end
   end

   // An entry is live when its distance from the head is below the occupancy
   always_comb begin
      rd_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (({1'b0, QA'(QA'(i) - hi)} < count) && (addr_m[i][31:OB] == rd_addr[31:OB]))
            rd_hit = 1'b1;
   end
endmodule
